sar_adc_scan_ctrl: RTL
======================

Name: sar_adc_scan_ctrl

Overview:
Multi-channel SAR ADC sequencer. It scans a programmable set of analog channels through one shared sample-and-hold, capacitive DAC and comparator, and runs a binary search per channel. Each result is delivered on a valid/ready stream tagged with its channel index. It sits between the analog front-end (mux, S&H, DAC, comparator) and the digital result consumer.

Parameters:
RESOLUTION, 8, SAR bits per conversion (>=2)
NUM_CHANNELS, 4, analog inputs scanned (>=1)
SAMPLE_CYCLES, 2, clock cycles sample_o held high per channel (>=1)
CH_W, $clog2(NUM_CHANNELS) (min 1), channel index width (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  scan request; sampled only in IDLE
ch_mask_i  in  NUM_CHANNELS  channel enable set; latched on accepted start
comp_i  in  1  comparator: 1 = DAC level above input
sample_o  out  1  S&H track enable
ch_sel_o  out  CH_W  analog mux select
dac_o  out  RESOLUTION  DAC code
busy_o  out  1  high whenever state != IDLE
result_o  out  RESOLUTION  conversion result
result_ch_o  out  CH_W  channel of result_o
valid_o  out  1  result available
ready_i  in  1  consumer accepts result
done_o  out  1  one-cycle pulse after last result of a scan transfers

Behaviour:
- Reset values: state IDLE; sample_o 0; ch_sel_o 0; dac_o 0; busy_o 0; result_o 0; result_ch_o 0; valid_o 0; done_o 0; latched mask 0.
- States are IDLE, SAMPLE, CONVERT and OUTPUT.
- IDLE:
  - start_i=1 and ch_mask_i!=0 at an edge: latch mask, set ch_sel_o to the lowest set bit, go to SAMPLE.
  - start_i=1 with ch_mask_i==0 is ignored; stay in IDLE, no done_o.
- SAMPLE:
  - sample_o=1 and dac_o=0 for exactly SAMPLE_CYCLES cycles.
  - Then go to CONVERT with dac_o = 1<<(RESOLUTION-1) and bit index b = RESOLUTION-1.
- CONVERT: one bit per cycle, RESOLUTION cycles in total. At each edge:
  - if comp_i=1, clear bit b of the code;
  - if b>0, set bit b-1 and decrement b.
  - After the bit-0 decision, load the final code into result_o, ch_sel_o into result_ch_o, assert valid_o and go to OUTPUT.
- OUTPUT:
  - valid_o stays high; result_o and result_ch_o are stable until the handshake completes. dac_o holds the final code.
  - Transfer happens on an edge with valid_o && ready_i.
  - If another latched channel bit above the current one exists, deassert valid_o, select the next higher set channel and go to SAMPLE.
  - Otherwise deassert valid_o, pulse done_o for one cycle, go to IDLE.
- ready_i high before valid_o rises is legal; valid_o is still high for at least one cycle.
- valid_o never drops without a transfer.
- Latency per channel with ready_i tied high: SAMPLE_CYCLES + RESOLUTION + 1 cycles from SAMPLE entry to transfer.
- start_i while busy_o=1 is ignored. ch_mask_i changes mid-scan have no effect.
- rst_ni low at any time aborts the scan immediately and returns all outputs to reset values. No partial result and no done_o.
- result_o retains its last value in IDLE.
- Codes are unsigned; no arithmetic overflow is possible without the optional feature.

Optional Feature:
Macro: SAR_ADC_AVG4_EN.
- Defined:
  - Each enabled channel is converted 4 times back-to-back, each conversion with its own SAMPLE phase.
  - Codes are summed in a RESOLUTION+2-bit accumulator, cleared when the channel starts.
  - result_o = sum>>2 (truncating).
  - valid_o asserts only after the 4th conversion.
  - Per-channel latency becomes 4*(SAMPLE_CYCLES+RESOLUTION)+1.
- Undefined: single conversion per channel as above, and no accumulator logic.

Test Plan:
- Comparator model: comp_i = (dac_o > vin[ch_sel_o]), with RESOLUTION=8, NUM_CHANNELS=4, SAMPLE_CYCLES=2.
- Single channel: mask 4'b0001, vin0=0x5A, ready_i=1 -> DAC trials 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A,0x5B. Then result_o=0x5A, result_ch_o=0, valid_o high 1 cycle, done_o pulses the next cycle, 11 cycles from SAMPLE entry to transfer.
- Sparse scan: mask 4'b1010, vin1=0x00, vin3=0xFF -> result 0x00 ch1, then 0xFF ch3, then one done_o; channels 0/2 never selected.
- Backpressure: ready_i=0 for 20 cycles in OUTPUT -> valid_o, result_o and result_ch_o stable for all 20 cycles; next channel starts only after the ready_i=1 edge.
- Ignored starts: start_i with mask 0 -> busy_o stays 0; start_i pulsed during CONVERT -> no restart, results unchanged.
- Reset mid-CONVERT: rst_ni low at bit 4 -> all outputs 0 asynchronously. After release and a new start (mask 4'b0100, vin2=0x3C) -> result 0x3C ch2.
- SAR_ADC_AVG4_EN: vin0 sequence 0x10,0x11,0x12,0x12 -> result_o=0x11, valid_o after 4*(2+8)+1=41 cycles.

Source files
------------

// File: rtl/sar_adc_scan_ctrl.sv
// Multi-channel SAR ADC scan sequencer: sample, binary search, valid/ready result per enabled channel.
// Optional macro SAR_ADC_AVG4_EN averages four conversions per channel before the result is offered.
module sar_adc_scan_ctrl #(
  parameter int  RESOLUTION    = 8,
  parameter int  NUM_CHANNELS  = 4,
  parameter int  SAMPLE_CYCLES = 2,
  localparam int CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [NUM_CHANNELS-1:0] ch_mask_i,
  input  logic                    comp_i,
  output logic                    sample_o,
  output logic [CH_W-1:0]         ch_sel_o,
  output logic [RESOLUTION-1:0]   dac_o,
  output logic                    busy_o,
  output logic [RESOLUTION-1:0]   result_o,
  output logic [CH_W-1:0]         result_ch_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    done_o
);

  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int BIT_W = $clog2(RESOLUTION);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, OUTPUT} state_e;

  state_e                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [RESOLUTION-1:0]   dac_q, dac_d;
  logic [RESOLUTION-1:0]   res_q, res_d;
  logic [CH_W-1:0]         res_ch_q, res_ch_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic [RESOLUTION-1:0]   code;
  logic [CH_W:0]           nxt;
`ifdef SAR_ADC_AVG4_EN
  logic [RESOLUTION+1:0]   acc_q, acc_d, sum;
  logic [1:0]              conv_q, conv_d;
`endif

  // Lowest set mask bit strictly above 'above'; MSB of the return flags that one exists.
  function automatic logic [CH_W:0] next_ch(input logic [NUM_CHANNELS-1:0] m, input int above);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (m[i] && (i > above)) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    ch_d     = ch_q;
    dac_d    = dac_q;
    res_d    = res_q;
    res_ch_d = res_ch_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    code     = dac_q;
    nxt      = '0;
`ifdef SAR_ADC_AVG4_EN
    acc_d    = acc_q;
    conv_d   = conv_q;
    sum      = '0;
`endif
    case (state_q)
      IDLE: begin
        nxt = next_ch(ch_mask_i, -1);
        if (start_i && nxt[CH_W]) begin
          mask_d  = ch_mask_i;
          ch_d    = nxt[CH_W-1:0];
          cnt_d   = '0;
          dac_d   = '0;
          state_d = SAMPLE;
`ifdef SAR_ADC_AVG4_EN
          acc_d   = '0;
          conv_d  = '0;
`endif
        end
      end
      SAMPLE: begin
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          dac_d   = {1'b1, {(RESOLUTION-1){1'b0}}};
          bit_d   = BIT_W'(RESOLUTION - 1);
          state_d = CONVERT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONVERT: begin
        // Keep the trial bit only if the DAC level did not exceed the input.
        if (comp_i) code[bit_q] = 1'b0;
        if (bit_q != '0) begin
          code[bit_q - 1'b1] = 1'b1;
          bit_d = bit_q - 1'b1;
          dac_d = code;
        end else begin
`ifdef SAR_ADC_AVG4_EN
          sum = acc_q + {2'b00, code};
          if (conv_q == 2'd3) begin
            res_d    = sum[RESOLUTION+1:2];
            res_ch_d = ch_q;
            valid_d  = 1'b1;
            dac_d    = code;
            state_d  = OUTPUT;
          end else begin
            acc_d   = sum;
            conv_d  = conv_q + 1'b1;
            cnt_d   = '0;
            dac_d   = '0;
            state_d = SAMPLE;
          end
`else
          res_d    = code;
          res_ch_d = ch_q;
          valid_d  = 1'b1;
          dac_d    = code;
          state_d  = OUTPUT;
`endif
        end
      end
      OUTPUT: begin
        if (ready_i) begin
          valid_d = 1'b0;
          nxt     = next_ch(mask_q, int'(ch_q));
          dac_d   = '0;
          if (nxt[CH_W]) begin
            ch_d    = nxt[CH_W-1:0];
            cnt_d   = '0;
            state_d = SAMPLE;
`ifdef SAR_ADC_AVG4_EN
            acc_d   = '0;
            conv_d  = '0;
`endif
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q   <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      ch_q     <= '0;
      dac_q    <= '0;
      res_q    <= '0;
      res_ch_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef SAR_ADC_AVG4_EN
      acc_q    <= '0;
      conv_q   <= '0;
`endif
    end else begin
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      ch_q     <= ch_d;
      dac_q    <= dac_d;
      res_q    <= res_d;
      res_ch_q <= res_ch_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef SAR_ADC_AVG4_EN
      acc_q    <= acc_d;
      conv_q   <= conv_d;
`endif
    end
  end

  assign sample_o    = (state_q == SAMPLE);
  assign busy_o      = (state_q != IDLE);
  assign ch_sel_o    = ch_q;
  assign dac_o       = dac_q;
  assign result_o    = res_q;
  assign result_ch_o = res_ch_q;
  assign valid_o     = valid_q;
  assign done_o      = done_q;

endmodule
